ctrl_unit_mc: RTL and testbench

//  Multi-cycle, stall-aware control unit and PC sequencer for the simple processor. Generalised in data and register-address width.

---
 rtl/ctrl_unit_mc_pkg.sv | 85 ++++++++
 rtl/ctrl_unit_mc_branch_target.sv | 15 +
 rtl/ctrl_unit_mc.sv | 149 ++++++++++++++
 tb/tb_ctrl_unit_mc.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_unit_mc_pkg.sv
// Shared definitions for the multi-cycle control unit: FSM states,
// opcodes, ALU function codes and the opcode decode helper.
package ctrl_unit_mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_LWD   = 8'h08;
  localparam logic [7:0] OP_LWI   = 8'h09;
  localparam logic [7:0] OP_SWD   = 8'h0A;
  localparam logic [7:0] OP_SWI   = 8'h0B;
  localparam logic [7:0] OP_BNE   = 8'h0C;
  localparam logic [7:0] OP_SLL   = 8'h0D;
  localparam logic [7:0] OP_SRL   = 8'h0E;

  localparam logic [2:0] ALU_FWD   = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_CMP   = 3'b101;
  localparam logic [2:0] ALU_ADDR  = 3'b110;
  localparam logic [2:0] ALU_SHIFT = 3'b111;

  // Per-opcode control summary; fields are independent of the FSM state.
  typedef struct packed {
    logic       alu_wr;      // result written back in EXEC
    logic       jump;
    logic       beq;
    logic       bne;
    logic       load;
    logic       store;
    logic       illegal;
    logic       sel_neg;
    logic       sel_reg;
    logic       shift_right;
    logic [2:0] alu_op;
  } decode_t;

  // sub negates source 2 and adds; beq/bne use the compare code with the
  // same negated operand so ZERO reflects equality.
  function automatic decode_t decode_op(input logic [7:0] op, input logic shift_en);
    decode_t d;
    d = '0;
    case (op)
      OP_LOADI: begin d.alu_wr = 1'b1; d.alu_op = ALU_FWD; end
      OP_MOV:   begin d.alu_wr = 1'b1; d.alu_op = ALU_FWD; d.sel_reg = 1'b1; end
      OP_ADD:   begin d.alu_wr = 1'b1; d.alu_op = ALU_ADD; d.sel_reg = 1'b1; end
      OP_SUB:   begin d.alu_wr = 1'b1; d.alu_op = ALU_ADD; d.sel_reg = 1'b1; d.sel_neg = 1'b1; end
      OP_AND:   begin d.alu_wr = 1'b1; d.alu_op = ALU_AND; d.sel_reg = 1'b1; end
      OP_OR:    begin d.alu_wr = 1'b1; d.alu_op = ALU_OR;  d.sel_reg = 1'b1; end
      OP_J:     d.jump = 1'b1;
      OP_BEQ:   begin d.beq = 1'b1; d.alu_op = ALU_CMP; d.sel_reg = 1'b1; d.sel_neg = 1'b1; end
      OP_BNE:   begin d.bne = 1'b1; d.alu_op = ALU_CMP; d.sel_reg = 1'b1; d.sel_neg = 1'b1; end
      OP_LWD:   begin d.load = 1'b1;  d.alu_op = ALU_ADDR; d.sel_reg = 1'b1; end
      OP_LWI:   begin d.load = 1'b1;  d.alu_op = ALU_ADDR; end
      OP_SWD:   begin d.store = 1'b1; d.alu_op = ALU_ADDR; d.sel_reg = 1'b1; end
      OP_SWI:   begin d.store = 1'b1; d.alu_op = ALU_ADDR; end
      OP_SLL, OP_SRL: begin
        if (shift_en) begin
          d.alu_wr      = 1'b1;
          d.alu_op      = ALU_SHIFT;
          d.shift_right = (op == OP_SRL);
        end else begin
          d.illegal = 1'b1;
        end
      end
      default:  d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ctrl_unit_mc_branch_target.sv
// Branch/jump target: PC + 4 + (sign-extended 8-bit offset << 2), modulo 2^PC_W.
module ctrl_unit_mc_branch_target #(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0] pc,
  input  logic [7:0]      offset,
  output logic [PC_W-1:0] target
);

  // Word offset relative to the following instruction
  always_comb begin
    target = pc + PC_W'(4) + (PC_W'($signed(offset)) << 2);
  end

endmodule

// File: rtl/ctrl_unit_mc.sv
// Multi-cycle control unit and PC sequencer: FETCH/DECODE/EXEC/MEM/WB.
// Stall handshake: ICACHE_BUSY and DCACHE_BUSY are inverted ready signals;
// a fetch or dcache access completes on a clock edge where busy is low,
// and the request (state, MEM_READ/MEM_WRITE) is held stable until then.
module ctrl_unit_mc
  import ctrl_unit_mc_pkg::*;
#(
  parameter int              DATA_W     = 8,
  parameter int              REG_ADDR_W = 3,
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int              SHIFT_EN   = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           INST,
  input  logic                  ICACHE_BUSY,
  input  logic                  DCACHE_BUSY,
  input  logic                  ZERO,
  output logic [PC_W-1:0]       PC,
  output logic [REG_ADDR_W-1:0] INADDRESS,
  output logic [REG_ADDR_W-1:0] OUT1ADDRESS,
  output logic [REG_ADDR_W-1:0] OUT2ADDRESS,
  output logic [DATA_W-1:0]     IMM,
  output logic [2:0]            ALU_OP,
  output logic                  SHIFT_RIGHT,
  output logic                  SEL_NEG,
  output logic                  SEL_REG,
  output logic                  SEL_MEM,
  output logic                  WRITE,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic                  ILLEGAL,
  output state_t                STATE
);

  state_t          state, state_nxt;
  logic [31:0]     ir, ir_nxt;
  logic [PC_W-1:0] pc_nxt, pc_plus4, pc_target;
  decode_t         dec;
  logic            take_branch;
  logic            unused_ir;

  ctrl_unit_mc_branch_target #(.PC_W(PC_W)) u_branch_target (
    .pc     (PC),
    .offset (ir[23:16]),
    .target (pc_target)
  );

  assign dec         = decode_op(ir[31:24], SHIFT_EN != 0);
  assign pc_plus4    = PC + PC_W'(4);
  assign take_branch = dec.jump | (dec.beq & ZERO) | (dec.bne & ~ZERO);

  // Operand fields come straight from IR, which is frozen from DECODE to WB
  assign INADDRESS   = ir[16 +: REG_ADDR_W];
  assign OUT1ADDRESS = ir[8 +: REG_ADDR_W];
  assign OUT2ADDRESS = ir[0 +: REG_ADDR_W];
  assign IMM         = DATA_W'($signed(ir[7:0]));
  assign STATE       = state;
  assign unused_ir   = ^ir;

  // State, IR and PC registers; RESET wins over any pending access
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_FETCH;
      ir    <= '0;
      PC    <= RESET_PC;
    end else begin
      state <= state_nxt;
      ir    <= ir_nxt;
      PC    <= pc_nxt;
    end
  end

  // Next state, IR capture and PC update
  always_comb begin
    state_nxt = state;
    ir_nxt    = ir;
    pc_nxt    = PC;
    case (state)
      S_FETCH: begin
        if (!ICACHE_BUSY) begin
          ir_nxt    = INST;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (dec.load || dec.store) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_FETCH;
          pc_nxt    = take_branch ? pc_target : pc_plus4;
        end
      end
      S_MEM: begin
        // Busy is only examined from inside MEM, never on the entry edge
        if (!DCACHE_BUSY) begin
          if (dec.load) begin
            state_nxt = S_WB;
          end else begin
            state_nxt = S_FETCH;
            pc_nxt    = pc_plus4;
          end
        end
      end
      S_WB: begin
        state_nxt = S_FETCH;
        pc_nxt    = pc_plus4;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Datapath controls; ALU selects stay valid from EXEC through WB
  always_comb begin
    ALU_OP      = 3'b000;
    SHIFT_RIGHT = 1'b0;
    SEL_NEG     = 1'b0;
    SEL_REG     = 1'b0;
    SEL_MEM     = 1'b0;
    WRITE       = 1'b0;
    MEM_READ    = 1'b0;
    MEM_WRITE   = 1'b0;
    ILLEGAL     = 1'b0;
    if (state == S_EXEC || state == S_MEM || state == S_WB) begin
      ALU_OP      = dec.alu_op;
      SHIFT_RIGHT = dec.shift_right;
      SEL_NEG     = dec.sel_neg;
      SEL_REG     = dec.sel_reg;
    end
    case (state)
      S_EXEC: begin
        WRITE   = dec.alu_wr;
        ILLEGAL = dec.illegal;
      end
      S_MEM: begin
        MEM_READ  = dec.load;
        MEM_WRITE = dec.store;
      end
      S_WB: begin
        WRITE   = 1'b1;
        SEL_MEM = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_unit_mc.sv
// Bench for ctrl_unit_mc: two instances share stimulus, one with shifts
// enabled and RESET_PC=0, one with shifts disabled and RESET_PC=0xFFFFFFF8.
module tb_ctrl_unit_mc;
  import ctrl_unit_mc_pkg::*;

  localparam logic [31:0] RPC0 = 32'h0000_0000;
  localparam logic [31:0] RPC1 = 32'hFFFF_FFF8;

  localparam int C_ALU = 0, C_J = 1, C_BEQ = 2, C_BNE = 3, C_LOAD = 4, C_STORE = 5, C_ILL = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [31:0] inst = '0;
  logic        icache_busy = 1'b0;
  logic        dcache_busy = 1'b0;
  logic        zero = 1'b0;

  logic [31:0] pc_o[2];
  logic [2:0]  inaddr_o[2], out1_o[2], out2_o[2], alu_op_o[2];
  logic [7:0]  imm_o[2];
  logic        shr_o[2], sel_neg_o[2], sel_reg_o[2], sel_mem_o[2];
  logic        write_o[2], mem_read_o[2], mem_write_o[2], illegal_o[2];
  state_t      state_o[2];

  ctrl_unit_mc #(.DATA_W(8), .REG_ADDR_W(3), .PC_W(32), .RESET_PC(RPC0), .SHIFT_EN(1)) dut0 (
    .CLK(clk), .RESET(reset), .INST(inst), .ICACHE_BUSY(icache_busy),
    .DCACHE_BUSY(dcache_busy), .ZERO(zero), .PC(pc_o[0]), .INADDRESS(inaddr_o[0]),
    .OUT1ADDRESS(out1_o[0]), .OUT2ADDRESS(out2_o[0]), .IMM(imm_o[0]), .ALU_OP(alu_op_o[0]),
    .SHIFT_RIGHT(shr_o[0]), .SEL_NEG(sel_neg_o[0]), .SEL_REG(sel_reg_o[0]),
    .SEL_MEM(sel_mem_o[0]), .WRITE(write_o[0]), .MEM_READ(mem_read_o[0]),
    .MEM_WRITE(mem_write_o[0]), .ILLEGAL(illegal_o[0]), .STATE(state_o[0])
  );

  ctrl_unit_mc #(.DATA_W(8), .REG_ADDR_W(3), .PC_W(32), .RESET_PC(RPC1), .SHIFT_EN(0)) dut1 (
    .CLK(clk), .RESET(reset), .INST(inst), .ICACHE_BUSY(icache_busy),
    .DCACHE_BUSY(dcache_busy), .ZERO(zero), .PC(pc_o[1]), .INADDRESS(inaddr_o[1]),
    .OUT1ADDRESS(out1_o[1]), .OUT2ADDRESS(out2_o[1]), .IMM(imm_o[1]), .ALU_OP(alu_op_o[1]),
    .SHIFT_RIGHT(shr_o[1]), .SEL_NEG(sel_neg_o[1]), .SEL_REG(sel_reg_o[1]),
    .SEL_MEM(sel_mem_o[1]), .WRITE(write_o[1]), .MEM_READ(mem_read_o[1]),
    .MEM_WRITE(mem_write_o[1]), .ILLEGAL(illegal_o[1]), .STATE(state_o[1])
  );

  // ---------------- scoreboard state ----------------
  int          errors = 0;
  int          checks = 0;
  logic [31:0] pc_m[2];
  logic [31:0] exp_q[$];

  // ---------------- reference model ----------------
  function automatic int op_class(input logic [7:0] op, input bit shift_en);
    case (op)
      8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05: return C_ALU;
      8'h06: return C_J;
      8'h07: return C_BEQ;
      8'h0C: return C_BNE;
      8'h08, 8'h09: return C_LOAD;
      8'h0A, 8'h0B: return C_STORE;
      8'h0D, 8'h0E: return shift_en ? C_ALU : C_ILL;
      default: return C_ILL;
    endcase
  endfunction

  // Expected ALU code, or -1 where the opcode table leaves it open
  function automatic int exp_alu_op(input logic [7:0] op);
    case (op)
      8'h00, 8'h01: return 0;
      8'h02: return 1;
      8'h04: return 2;
      8'h05: return 3;
      8'h08, 8'h09, 8'h0A, 8'h0B: return 6;
      8'h0D, 8'h0E: return 7;
      default: return -1;
    endcase
  endfunction

  function automatic int exp_sel_reg(input logic [7:0] op);
    case (op)
      8'h00, 8'h09, 8'h0B, 8'h0D, 8'h0E: return 0;
      8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h07, 8'h08, 8'h0A, 8'h0C: return 1;
      default: return -1;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int ncyc);
    reset = 1'b1;
    icache_busy = 1'b0;
    dcache_busy = 1'b0;
    repeat (ncyc) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    pc_m[0] = RPC0;
    pc_m[1] = RPC1;
  endtask

  // Runs one instruction from FETCH back to FETCH, checking every cycle.
  // ic: icache busy cycles, dc: dcache busy cycles inside MEM.
  task automatic run_instr(input logic [31:0] ins, input int ic, input int dc, input logic z);
    int          cls[2];
    logic [31:0] off, nxt;
    bit          mem, ld;
    int          total, mem_first, mem_last, ea;
    logic [4:0]  exp_ctl, act_ctl;
    off = {{24{ins[23]}}, ins[23:16]};
    for (int d = 0; d < 2; d++) begin
      cls[d] = op_class(ins[31:24], d == 0);
      case (cls[d])
        C_J:     nxt = pc_m[d] + 32'd4 + (off << 2);
        C_BEQ:   nxt = z ? pc_m[d] + 32'd4 + (off << 2) : pc_m[d] + 32'd4;
        C_BNE:   nxt = !z ? pc_m[d] + 32'd4 + (off << 2) : pc_m[d] + 32'd4;
        default: nxt = pc_m[d] + 32'd4;
      endcase
      exp_q.push_back(nxt);
    end
    mem       = (cls[0] == C_LOAD) || (cls[0] == C_STORE);
    ld        = (cls[0] == C_LOAD);
    mem_first = ic + 3;
    mem_last  = ic + 3 + dc;
    total     = ic + 3 + (mem ? dc + 1 : 0) + (ld ? 1 : 0);
    for (int c = 0; c < total; c++) begin
      icache_busy = (c < ic) ? 1'b1 : ((c == ic) ? 1'b0 : 1'($urandom_range(0, 1)));
      inst        = (c == ic) ? ins : $urandom;
      zero        = (c == ic + 2) ? z : 1'($urandom_range(0, 1));
      if (mem && c >= mem_first && c <= mem_last) dcache_busy = (c < mem_last);
      else dcache_busy = 1'($urandom_range(0, 1));
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        exp_ctl = 5'b0;  // {WRITE, SEL_MEM, MEM_READ, MEM_WRITE, ILLEGAL}
        if (c == ic + 2 && cls[d] == C_ALU) exp_ctl[4] = 1'b1;
        if (c == ic + 2 && cls[d] == C_ILL) exp_ctl[0] = 1'b1;
        if (mem && c >= mem_first && c <= mem_last) begin
          exp_ctl[2] = ld;
          exp_ctl[1] = !ld;
        end
        if (ld && c == mem_last + 1) exp_ctl[4:3] = 2'b11;
        act_ctl = {write_o[d], sel_mem_o[d], mem_read_o[d], mem_write_o[d], illegal_o[d]};
        checks++;
        if (act_ctl !== exp_ctl) begin
          errors++;
          $display("FAIL ctl dut%0d ins=%h cyc=%0d: got %b expected %b", d, ins, c, act_ctl, exp_ctl);
        end
        checks++;
        if (pc_o[d] !== pc_m[d]) begin
          errors++;
          $display("FAIL pc_hold dut%0d ins=%h cyc=%0d: got %h expected %h", d, ins, c, pc_o[d], pc_m[d]);
        end
        if (c == ic + 1) begin
          checks++;
          if ({inaddr_o[d], out1_o[d], out2_o[d], imm_o[d]} !== {ins[18:16], ins[10:8], ins[2:0], ins[7:0]}) begin
            errors++;
            $display("FAIL fields dut%0d ins=%h: got %h/%h/%h/%h", d, ins,
                     inaddr_o[d], out1_o[d], out2_o[d], imm_o[d]);
          end
        end
        if (c == ic + 2 && cls[d] != C_ILL) begin
          ea = exp_alu_op(ins[31:24]);
          if (ea >= 0) begin
            checks++;
            if (alu_op_o[d] !== 3'(ea)) begin
              errors++;
              $display("FAIL alu_op dut%0d ins=%h: got %b expected %b", d, ins, alu_op_o[d], 3'(ea));
            end
          end
          checks++;
          if (sel_neg_o[d] !== (ins[31:24] == 8'h03 || ins[31:24] == 8'h07 || ins[31:24] == 8'h0C)) begin
            errors++;
            $display("FAIL sel_neg dut%0d ins=%h: got %b", d, ins, sel_neg_o[d]);
          end
          if (exp_sel_reg(ins[31:24]) >= 0) begin
            checks++;
            if (sel_reg_o[d] !== 1'(exp_sel_reg(ins[31:24]))) begin
              errors++;
              $display("FAIL sel_reg dut%0d ins=%h: got %b", d, ins, sel_reg_o[d]);
            end
          end
          if (ea == 7) begin
            checks++;
            if (shr_o[d] !== (ins[31:24] == 8'h0E)) begin
              errors++;
              $display("FAIL shift_right dut%0d ins=%h: got %b", d, ins, shr_o[d]);
            end
          end
        end
      end
      @(posedge clk);
      #1;
    end
    for (int d = 0; d < 2; d++) begin
      pc_m[d] = exp_q.pop_front();
      checks++;
      if (pc_o[d] !== pc_m[d] || state_o[d] !== S_FETCH) begin
        errors++;
        $display("FAIL pc_next dut%0d ins=%h: got pc=%h state=%0d expected pc=%h state=%0d",
                 d, ins, pc_o[d], state_o[d], pc_m[d], S_FETCH);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    logic [31:0] lwd;
    do_reset(2);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (pc_o[d] !== pc_m[d] || state_o[d] !== S_FETCH ||
          {write_o[d], mem_read_o[d], mem_write_o[d], illegal_o[d], sel_mem_o[d],
           sel_reg_o[d], sel_neg_o[d], alu_op_o[d]} !== 10'b0) begin
        errors++;
        $display("FAIL reset_state dut%0d: pc=%h state=%0d ctl=%b%b%b%b alu=%b", d, pc_o[d],
                 state_o[d], write_o[d], mem_read_o[d], mem_write_o[d], illegal_o[d], alu_op_o[d]);
      end
    end
    // Move PC away from reset value, then reset in the middle of a load
    run_instr(32'h0001_0005, 0, 0, 1'b0);
    run_instr(32'h0202_0001, 0, 0, 1'b0);
    lwd = 32'h0802_0001;
    inst = lwd;
    icache_busy = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      inst = $urandom;
    end
    dcache_busy = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_read_o[0] !== 1'b1 || mem_read_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL mid_mem_read: got %b/%b expected 1/1", mem_read_o[0], mem_read_o[1]);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (mem_read_o[d] !== 1'b0 || pc_o[d] !== (d == 0 ? RPC0 : RPC1) || state_o[d] !== S_FETCH) begin
        errors++;
        $display("FAIL reset_mid_mem dut%0d: mem_read=%b pc=%h state=%0d", d, mem_read_o[d], pc_o[d], state_o[d]);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    dcache_busy = 1'b0;
    pc_m[0] = RPC0;
    pc_m[1] = RPC1;
  endtask

  task automatic test_add;
    run_instr(32'h0203_0102, 0, 0, 1'b0);
    checks++;
    if (pc_o[0] !== 32'h4) begin
      errors++;
      $display("FAIL add_pc: got %h expected 00000004", pc_o[0]);
    end
  endtask

  task automatic test_load_stall;
    run_instr(32'h0802_0001, 0, 3, 1'b0);
    run_instr(32'h0A00_0302, 1, 2, 1'b1);
    run_instr(32'h0905_0010, 0, 0, 1'b0);
    run_instr(32'h0B00_0480, 0, 0, 1'b0);
  endtask

  task automatic goto_0x10;
    do_reset(1);
    for (int i = 0; i < 4; i++) run_instr(32'h0000_0000 | 32'(i), 0, 0, 1'b0);
  endtask

  task automatic test_branch;
    goto_0x10();
    run_instr(32'h07FE_0102, 0, 0, 1'b1);
    checks++;
    if (pc_o[0] !== 32'h0C) begin
      errors++;
      $display("FAIL beq_taken: got %h expected 0000000c", pc_o[0]);
    end
    goto_0x10();
    run_instr(32'h07FE_0102, 0, 0, 1'b0);
    checks++;
    if (pc_o[0] !== 32'h14) begin
      errors++;
      $display("FAIL beq_not_taken: got %h expected 00000014", pc_o[0]);
    end
    goto_0x10();
    run_instr(32'h0CFE_0102, 0, 0, 1'b1);
    checks++;
    if (pc_o[0] !== 32'h14) begin
      errors++;
      $display("FAIL bne_not_taken: got %h expected 00000014", pc_o[0]);
    end
    goto_0x10();
    run_instr(32'h0CFE_0102, 0, 0, 1'b0);
    checks++;
    if (pc_o[0] !== 32'h0C) begin
      errors++;
      $display("FAIL bne_taken: got %h expected 0000000c", pc_o[0]);
    end
  endtask

  task automatic test_illegal;
    run_instr(32'h0D01_0203, 0, 0, 1'b0);
    run_instr(32'h0E02_0301, 1, 0, 1'b0);
    run_instr(32'hFF01_0203, 0, 0, 1'b1);
    run_instr(32'h0F00_0000, 0, 0, 1'b0);
  endtask

  task automatic test_icache_stall;
    run_instr(32'h0205_0607, 5, 0, 1'b0);
    run_instr(32'h0406_0705, 2, 0, 1'b0);
  endtask

  task automatic test_jump_wrap;
    do_reset(1);
    run_instr(32'h067F_0000, 0, 0, 1'b0);
    checks++;
    if (pc_o[1] !== 32'h0000_01F8) begin
      errors++;
      $display("FAIL jump_wrap: got %h expected 000001f8", pc_o[1]);
    end
  endtask

  task automatic test_random;
    logic [31:0] r, ins;
    logic [7:0]  op;
    for (int i = 0; i < 80; i++) begin
      r  = $urandom;
      op = ($urandom_range(0, 15) < 15) ? 8'($urandom_range(0, 14)) : 8'($urandom_range(15, 255));
      ins = {op, r[23:0]};
      run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    test_reset();
    test_add();
    test_load_stall();
    test_branch();
    test_illegal();
    test_icache_stall();
    test_jump_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "time limit");
  end

endmodule
